// File: rtl/muldiv_seq.sv
// ============================================================================
// Module   : muldiv_seq (with adder_32bit)
// Purpose  : Iterative RV32M multiply/divide unit, fixed 37-cycle latency,
//            built around a single 32-bit CLA add/sub unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_32bit (
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        sel,
  output logic [31:0] OUT,
  output logic        CarryOut
);
  logic [31:0] w_b;
  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [8:0]  w_gc;

  assign w_b     = B ^ {32{sel}};
  assign w_g     = A & w_b;
  assign w_p     = A ^ w_b;
  assign w_gc[0] = sel;

  // 4-bit lookahead groups, group carries rippled between groups.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_grp
      localparam int c_lsb = gi * 4;
      logic [4:0] w_c;
      assign w_c[0] = w_gc[gi];
      assign w_c[1] = w_g[c_lsb] | (w_p[c_lsb] & w_c[0]);
      assign w_c[2] = w_g[c_lsb+1] | (w_p[c_lsb+1] & w_g[c_lsb])
                    | (w_p[c_lsb+1] & w_p[c_lsb] & w_c[0]);
      assign w_c[3] = w_g[c_lsb+2] | (w_p[c_lsb+2] & w_g[c_lsb+1])
                    | (w_p[c_lsb+2] & w_p[c_lsb+1] & w_g[c_lsb])
                    | (w_p[c_lsb+2] & w_p[c_lsb+1] & w_p[c_lsb] & w_c[0]);
      assign w_c[4] = w_g[c_lsb+3] | (w_p[c_lsb+3] & w_g[c_lsb+2])
                    | (w_p[c_lsb+3] & w_p[c_lsb+2] & w_g[c_lsb+1])
                    | (w_p[c_lsb+3] & w_p[c_lsb+2] & w_p[c_lsb+1] & w_g[c_lsb])
                    | (w_p[c_lsb+3] & w_p[c_lsb+2] & w_p[c_lsb+1] & w_p[c_lsb] & w_c[0]);
      assign OUT[c_lsb+3:c_lsb] = w_p[c_lsb+3:c_lsb] ^ w_c[3:0];
      assign w_gc[gi+1] = w_c[4];
    end
  endgenerate

  assign CarryOut = w_gc[8];
endmodule

module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_NEG_A  = 3'd1,
    S_NEG_B  = 3'd2,
    S_ITER   = 3'd3,
    S_FIX_LO = 3'd4,
    S_FIX_HI = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t          r_state;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_a;     // rs1 -> |rs1| -> lo / quotient
  logic [XLEN-1:0] r_b;     // rs2 -> |rs2|
  logic [XLEN-1:0] r_hi;    // hi / remainder
  logic            r_sa;
  logic            r_sb;
  logic            r_div0;
  logic            r_c;
  logic [4:0]      r_cnt;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic [XLEN-1:0] w_add_a;
  logic [XLEN-1:0] w_add_b;
  logic            w_add_sel;
  logic [XLEN-1:0] w_sum;
  logic            w_cout;

  adder_32bit u_add (
    .A        (w_add_a),
    .B        (w_add_b),
    .sel      (w_add_sel),
    .OUT      (w_sum),
    .CarryOut (w_cout)
  );

  logic            w_rs1_signed;
  logic            w_rs2_signed;
  logic            w_is_div;
  logic            w_is_rem;
  logic            w_hi_op;
  logic            w_neg_prod;
  logic            w_neg_lo;
  logic            w_mulh_fix;
  logic [XLEN-1:0] w_rsh;
  logic            w_accept;
  logic [XLEN-1:0] w_fix_src;
  logic [XLEN-1:0] w_result;

  assign w_rs1_signed = (i_op == 3'b001) || (i_op == 3'b010) || (i_op == 3'b100) || (i_op == 3'b110);
  assign w_rs2_signed = (i_op == 3'b001) || (i_op == 3'b100) || (i_op == 3'b110);

  assign w_is_div   = r_op[2];
  assign w_is_rem   = r_op[2] & r_op[1];
  assign w_hi_op    = ~r_op[2] & (r_op[1:0] != 2'b00);
  assign w_neg_prod = r_sa ^ r_sb;
  // Remainder follows the dividend sign; quotient sign is suppressed for /0.
  assign w_neg_lo   = w_is_rem ? r_sa : (w_is_div ? (w_neg_prod & ~r_div0) : w_neg_prod);
  assign w_mulh_fix = w_hi_op & w_neg_prod;
  assign w_fix_src  = w_is_rem ? r_hi : r_a;

  assign w_rsh    = {r_hi[XLEN-2:0], r_a[XLEN-1]};
  assign w_accept = r_hi[XLEN-1] | w_cout;

  assign w_result = w_hi_op  ? (w_mulh_fix ? w_sum : r_hi) :
                    w_is_rem ? r_hi : r_a;

  always_comb begin
    w_add_a   = '0;
    w_add_b   = '0;
    w_add_sel = 1'b0;
    case (r_state)
      S_NEG_A: begin
        w_add_b   = r_a;
        w_add_sel = 1'b1;
      end
      S_NEG_B: begin
        w_add_b   = r_b;
        w_add_sel = 1'b1;
      end
      S_ITER: begin
        w_add_a   = w_is_div ? w_rsh : r_hi;
        w_add_b   = r_b;
        w_add_sel = w_is_div;
      end
      S_FIX_LO: begin
        w_add_b   = w_fix_src;
        w_add_sel = 1'b1;
      end
      S_FIX_HI: begin
        w_add_a   = ~r_hi;
        w_add_b   = {XLEN{r_c}};
        w_add_sel = r_c;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
      r_div0   <= 1'b0;
      r_c      <= 1'b0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if ((r_state != S_IDLE) && i_flush) begin
        r_state <= S_IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (i_start && !i_flush) begin
              r_op    <= i_op;
              r_a     <= i_rs1;
              r_b     <= i_rs2;
              r_hi    <= '0;
              r_sa    <= i_rs1[XLEN-1] & w_rs1_signed;
              r_sb    <= i_rs2[XLEN-1] & w_rs2_signed;
              r_div0  <= (i_rs2 == '0);
              r_cnt   <= '0;
              r_busy  <= 1'b1;
              r_state <= S_NEG_A;
            end
          end
          S_NEG_A: begin
            if (r_sa) r_a <= w_sum;
            r_state <= S_NEG_B;
          end
          S_NEG_B: begin
            if (r_sb) r_b <= w_sum;
            r_state <= S_ITER;
          end
          S_ITER: begin
            if (w_is_div) begin
              r_hi <= w_accept ? w_sum : w_rsh;
              r_a  <= {r_a[XLEN-2:0], w_accept};
            end else if (r_a[0]) begin
              r_hi <= {w_cout, w_sum[XLEN-1:1]};
              r_a  <= {w_sum[0], r_a[XLEN-1:1]};
            end else begin
              r_hi <= {1'b0, r_hi[XLEN-1:1]};
              r_a  <= {r_hi[0], r_a[XLEN-1:1]};
            end
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'(ITERS - 1)) r_state <= S_FIX_LO;
          end
          S_FIX_LO: begin
            // c is the carry out of negating the low half of the product.
            r_c <= (r_a == '0);
            if (w_neg_lo) begin
              if (w_is_rem) r_hi <= w_sum;
              else          r_a  <= w_sum;
            end
            r_state <= S_FIX_HI;
          end
          S_FIX_HI: begin
            if (w_mulh_fix) r_hi <= w_sum;
            r_result <= w_result;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
          S_DONE: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
          default: begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
endmodule

`default_nettype wire

// File: tb/tb_muldiv_seq.sv
// ============================================================================
// Module   : tb_muldiv_seq
// Purpose  : Directed bench for muldiv_seq with an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_start = 1'b0;
  logic [2:0]  i_op = 3'd0;
  logic [31:0] i_rs1 = '0;
  logic [31:0] i_rs2 = '0;
  logic        i_flush = 1'b0;
  logic        o_busy;
  logic        o_done;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;
  int done_seen = 0;

  muldiv_seq #(.XLEN(32), .ITERS(32)) dut (
    .i_clk    (clk),
    .i_reset  (rst),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_flush  (i_flush),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // RV32M reference semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic        ovf;
    ea  = (op == 3'd1 || op == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
    eb  = (op == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
    p   = ea * eb;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (op)
      3'd0:                model = p[31:0];
      3'd1, 3'd2, 3'd3:    model = p[63:32];
      3'd4: model = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: model = (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycle-level expectation: phase 0 idle, 1..37 busy, 37 is the done cycle.
  int          m_ph  = 0;
  logic [31:0] m_exp = '0;
  logic [31:0] m_res = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph  = 0;
      m_res = '0;
    end else if (m_ph == 0) begin
      if (i_start && !i_flush) begin
        m_ph  = 1;
        m_exp = model(i_op, i_rs1, i_rs2);
      end
    end else if (i_flush || m_ph == 37) begin
      m_ph = 0;
    end else begin
      m_ph++;
      if (m_ph == 37) m_res = m_exp;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, o_busy}, {31'd0, (m_ph != 0)});
      check("done", {31'd0, o_done}, {31'd0, (m_ph == 37)});
      check("result_hold", o_result, m_res);
      if (o_done) done_seen++;
    end
  end

  task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    i_start = 1'b1; i_op = op; i_rs1 = a; i_rs2 = b;
    @(posedge clk); #2;
    i_start = 1'b0;
  endtask

  // Returns the number of edges from the start-sampling edge until o_done.
  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (!o_done && lat < 60) begin
      @(posedge clk); #2;
      lat++;
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] lit);
    int lat;
    check({name, "_model"}, model(op, a, b), lit);
    start_op(op, a, b);
    wait_done(1, lat);
    check({name, "_latency"}, lat, 37);
    check(name, o_result, lit);
    @(posedge clk); #2;
  endtask

  initial begin
    int lat;
    int d0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("reset_busy", {31'd0, o_busy}, 32'd0);
    check("reset_done", {31'd0, o_done}, 32'd0);
    check("reset_result", o_result, 32'd0);
    chk_en = 1'b1;

    do_op("MUL",    3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB);
    do_op("MULH",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    do_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("MULHU",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    do_op("MULH_neg", 3'd1, 32'hFFFF_FFFE, 32'd3,       32'hFFFF_FFFF);
    do_op("DIV",    3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD);
    do_op("REM",    3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF);
    do_op("DIVU",   3'd5, 32'd100,       32'd7,         32'd14);
    do_op("REMU",   3'd7, 32'd100,       32'd7,         32'd2);
    do_op("DIV_0",  3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF);
    do_op("DIVn_0", 3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF);
    do_op("REMn_0", 3'd6, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB);
    do_op("DIV_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    do_op("REM_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

    // A second start while busy must be ignored.
    start_op(3'd5, 32'd100, 32'd7);
    lat = 1;
    while (lat < 10) begin @(posedge clk); #2; lat++; end
    i_start = 1'b1; i_op = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd5;
    @(posedge clk); #2; lat++;
    i_start = 1'b0;
    wait_done(lat, lat);
    check("ign_latency", lat, 37);
    check("ign_result", o_result, 32'd14);
    @(posedge clk); #2;
    check("ign_idle", {31'd0, o_busy}, 32'd0);

    // Flush mid-operation: back to idle, no done, result held.
    d0 = done_seen;
    start_op(3'd5, 32'd200, 32'd9);
    lat = 1;
    while (lat < 20) begin @(posedge clk); #2; lat++; end
    i_flush = 1'b1;
    @(posedge clk); #2;
    i_flush = 1'b0;
    check("flush_busy", {31'd0, o_busy}, 32'd0);
    check("flush_result", o_result, 32'd14);
    repeat (25) @(posedge clk);
    #2;
    check("flush_no_done", done_seen, d0);

    // Flush together with start in idle drops the start.
    i_start = 1'b1; i_flush = 1'b1; i_op = 3'd0; i_rs1 = 32'd2; i_rs2 = 32'd2;
    @(posedge clk); #2;
    i_start = 1'b0; i_flush = 1'b0;
    check("flush_start_drop", {31'd0, o_busy}, 32'd0);

    // Asynchronous reset mid-multiply.
    start_op(3'd0, 32'h1234, 32'h10);
    lat = 1;
    while (lat < 15) begin @(posedge clk); #2; lat++; end
    #1 rst = 1'b1;
    #1;
    check("arst_busy", {31'd0, o_busy}, 32'd0);
    check("arst_done", {31'd0, o_done}, 32'd0);
    check("arst_result", o_result, 32'd0);
    #2 rst = 1'b0;
    do_op("MUL_after_rst", 3'd0, 32'd6, 32'd7, 32'd42);

    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
